// File: rtl/mnv_axi_pkg.sv
// rtl/mnv_axi_pkg.sv - shared burst-read types for weight fetch responders and address generators
package mnv_axi_pkg;

    localparam int MAX_BURST = 16;
    // Beat counters hold 0..MAX_BURST inclusive.
    localparam int LEN_W     = $clog2(MAX_BURST) + 1;

    // Burst length encoded as beats-1.
    typedef logic [3:0] burst_len_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/weight_sram.sv
// rtl/weight_sram.sv - simple dual-port 1R1W weight SRAM, synchronous read, read-first
module weight_sram #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Write port; the array is never reset so preloaded weights survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port; sampling the array at the same edge as a write returns the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/weight_rd_responder.sv
// rtl/weight_rd_responder.sv - single-outstanding burst read responder over the weight SRAM
module weight_rd_responder
    import mnv_axi_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] araddr,
    input  logic          arvalid,
    input  burst_len_t    arburst,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rlast,
    input  logic          rready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int IW   = $clog2(DEPTH);
    localparam int BOFF = $clog2(DW / 8);

    rd_state_e         state_q, state_d;
    logic              arready_q, arready_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              sram_vld_q, sram_vld_d;
    logic              sram_last_q, sram_last_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              skid_vld_q, skid_vld_d;
    logic              skid_last_q, skid_last_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;

    logic [IW-1:0]     ar_idx;
    logic [IW-1:0]     wr_idx;
    logic              ar_hs;
    logic              cons;
    logic              last_hs;
    logic              issue_en;
    logic              issue_last;
    logic [IW-1:0]     issue_idx;
    logic [DW-1:0]     sram_rdata;
    logic              unused_addr_bits;

    // Byte offset and bits above the SRAM depth are dropped, so addresses wrap modulo DEPTH.
    assign ar_idx  = araddr[BOFF +: IW];
    assign wr_idx  = wr_addr[BOFF +: IW];
    assign unused_addr_bits = ^{araddr, wr_addr};

    assign ar_hs   = (state_q == IDLE) && arvalid && arready_q;
    assign cons    = rvalid_q && rready;
    assign last_hs = cons && rlast_q;

    // Read issue: the first beat is read in the handshake cycle so it reaches rvalid two
    // cycles later; later beats issue while fewer than two beats are in flight after this
    // cycle's consume, which is exactly what the output register plus skid can absorb.
    always_comb begin
        issue_en   = 1'b0;
        issue_last = 1'b0;
        issue_idx  = idx_q;
        if (ar_hs) begin
            issue_en   = 1'b1;
            issue_idx  = ar_idx;
            issue_last = (arburst == '0);
        end else if ((state_q == BURST) && (issued_q < len_q) &&
                     ((cnt_q < 2'd2) || cons)) begin
            issue_en   = 1'b1;
            issue_last = (issued_q == (len_q - LEN_W'(1)));
        end
    end

    weight_sram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_sram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (issue_en),
        .rd_idx  (issue_idx),
        .rd_data (sram_rdata)
    );

    // Burst FSM and beat bookkeeping: one outstanding burst, arready registered from next state.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d  = BURST;
                    len_d    = LEN_W'(arburst) + LEN_W'(1);
                    issued_d = LEN_W'(1);
                    idx_d    = ar_idx + IW'(1);
                end
            end
            BURST: begin
                if (issue_en) begin
                    issued_d = issued_q + LEN_W'(1);
                    idx_d    = idx_q + IW'(1);
                end
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
        cnt_d     = cnt_q + {1'b0, issue_en} - {1'b0, cons};
    end

    // Output register plus skid: SRAM data lands in the skid only when the output is stalled.
    always_comb begin
        sram_vld_d  = issue_en;
        sram_last_d = issue_last;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        if (!rvalid_q || cons) begin
            if (skid_vld_q) begin
                rvalid_d    = 1'b1;
                rlast_d     = skid_last_q;
                rdata_d     = skid_data_q;
                skid_vld_d  = sram_vld_q;
                skid_last_d = sram_last_q;
                skid_data_d = sram_rdata;
            end else if (sram_vld_q) begin
                rvalid_d = 1'b1;
                rlast_d  = sram_last_q;
                rdata_d  = sram_rdata;
            end else begin
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        end else if (sram_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_last_d = sram_last_q;
            skid_data_d = sram_rdata;
        end
    end

    // State and output registers; reset clears everything except the SRAM array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            len_q       <= '0;
            issued_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            sram_vld_q  <= 1'b0;
            sram_last_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sram_vld_q  <= sram_vld_d;
            sram_last_q <= sram_last_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;

endmodule
